// File: rtl/acc_seq_pkg.sv
// Shared definitions for the NSC-8 accumulator sequencer.
// Optional feature: ACC_SEQ_HALT_EN adds the HALT opcode and state.
package acc_seq_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_LDA  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_STA  = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_IMM,
    S_RD,
    S_LOAD,
    S_ALU,
    S_WB,
    S_STORE,
    S_DONE
`ifdef ACC_SEQ_HALT_EN
    , S_HALT
`endif
  } state_t;

  // Datapath strobes driven in a given state
  typedef struct packed {
    logic load_a;
    logic load_imm;
    logic acc_oe;
    logic imm_oe;
    logic mem_read;
    logic mem_write;
    logic alu_latch;
    logic alu_oe;
    logic done;
  } ctrl_t;

  // Strobe pattern for each state; at most one bus driver per state
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IMM:   begin c.imm_oe   = 1'b1; c.load_imm  = 1'b1; end
      S_RD:    begin c.mem_read = 1'b1; end
      S_LOAD:  begin c.mem_read = 1'b1; c.load_a    = 1'b1; end
      S_ALU:   begin c.mem_read = 1'b1; c.alu_latch = 1'b1; end
      S_WB:    begin c.alu_oe   = 1'b1; c.load_a    = 1'b1; end
      S_STORE: begin c.acc_oe   = 1'b1; c.mem_write = 1'b1; end
      S_DONE:  begin c.done     = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_seq_decode.sv
// Opcode decoder: first sequencer state after accept plus an illegal flag.
// Optional feature: ACC_SEQ_HALT_EN maps opcode 15 to HALT.
module acc_seq_decode
  import acc_seq_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output state_t              first_state_o,
  output logic                illegal_o
);

  // Map opcode to its entry state; undefined codes retire straight away
  always_comb begin
    first_state_o = S_DONE;
    illegal_o     = 1'b0;
    case (opcode_i)
      OP_NOP:  first_state_o = S_DONE;
      OP_LDI:  first_state_o = S_IMM;
      OP_LDA:  first_state_o = S_RD;
      OP_STA:  first_state_o = S_STORE;
      OP_ADD:  first_state_o = S_RD;
`ifdef ACC_SEQ_HALT_EN
      OP_HALT: first_state_o = S_HALT;
`endif
      default: begin
        first_state_o = S_DONE;
        illegal_o     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// NSC-8 accumulator/bus control sequencer. One instruction at a time,
// strobes registered from the next state so they align with the state.
// Optional feature: ACC_SEQ_HALT_EN enables the HALT opcode/state.
module acc_sequencer
  import acc_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic [DATA_W-1:0]   instr_operand,
  output logic                instr_ready,
  input  logic                mem_ready,
  output logic                load_a,
  output logic                load_immediate_a,
  output logic                output_enable,
  output logic [DATA_W-1:0]   imm_out,
  output logic                imm_oe,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_latch,
  output logic                alu_oe,
  output logic                done,
  output logic                illegal,
  output logic                halted
);

  state_t              state_q, state_d;
  state_t              first_state;
  logic                dec_illegal;
  logic                accept;
  logic [OPCODE_W-1:0] opcode_q;
  logic [DATA_W-1:0]   operand_q;
  logic                illegal_flag_q;
  logic                illegal_q;
  ctrl_t               ctrl_q;

  acc_seq_decode u_decode (
    .opcode_i      (instr_opcode),
    .first_state_o (first_state),
    .illegal_o     (dec_illegal)
  );

  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  // Next-state selection; RD and STORE stall until memory completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = first_state;
      S_IMM:   state_d = S_DONE;
      S_RD:    if (mem_ready) state_d = (opcode_q == OP_ADD) ? S_ALU : S_LOAD;
      S_LOAD:  state_d = S_DONE;
      S_ALU:   state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_STORE: if (mem_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
`ifdef ACC_SEQ_HALT_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured instruction and strobes decoded from the next state
  // so every output is a flop that tracks state_q exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      opcode_q       <= '0;
      operand_q      <= '0;
      illegal_flag_q <= 1'b0;
      illegal_q      <= 1'b0;
      ctrl_q         <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      if (accept) begin
        opcode_q       <= instr_opcode;
        operand_q      <= instr_operand;
        illegal_flag_q <= dec_illegal;
      end
      // an undefined opcode goes straight to DONE, so use the live decode then
      illegal_q <= (state_d == S_DONE) && (accept ? dec_illegal : illegal_flag_q);
    end
  end

`ifdef ACC_SEQ_HALT_EN
  logic halted_q;

  // Halt indicator, held until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= (state_d == S_HALT);
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign load_a           = ctrl_q.load_a;
  assign load_immediate_a = ctrl_q.load_imm;
  assign output_enable    = ctrl_q.acc_oe;
  assign imm_oe           = ctrl_q.imm_oe;
  assign mem_read         = ctrl_q.mem_read;
  assign mem_write        = ctrl_q.mem_write;
  assign alu_latch        = ctrl_q.alu_latch;
  assign alu_oe           = ctrl_q.alu_oe;
  assign done             = ctrl_q.done;
  assign illegal          = illegal_q;
  assign imm_out          = operand_q;
  assign mem_addr         = operand_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: driver pushes each accepted
// instruction, monitor collects the per-cycle strobe trace and compares
// it on done against a phase-list model of the instruction.
module tb_acc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_ready;
  logic       mem_ready;
  logic       load_a, load_immediate_a, output_enable, imm_oe;
  logic [7:0] imm_out, mem_addr;
  logic       mem_read, mem_write, alu_latch, alu_oe;
  logic       done, illegal, halted;

  acc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr_opcode     (instr_opcode),
    .instr_operand    (instr_operand),
    .instr_ready      (instr_ready),
    .mem_ready        (mem_ready),
    .load_a           (load_a),
    .load_immediate_a (load_immediate_a),
    .output_enable    (output_enable),
    .imm_out          (imm_out),
    .imm_oe           (imm_oe),
    .mem_addr         (mem_addr),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .alu_latch        (alu_latch),
    .alu_oe           (alu_oe),
    .done             (done),
    .illegal          (illegal),
    .halted           (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // trace vector bits
  localparam int B_LDA = 9, B_LDI = 8, B_OE = 7, B_IMMOE = 6, B_MRD = 5;
  localparam int B_MWR = 4, B_LATCH = 3, B_ALUOE = 2, B_DONE = 1, B_ILL = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] operand;
    int         w;
    bit         hold;
    int         gap;
  } item_t;

  item_t items[$];
  item_t exp_q[$];
  logic [9:0] trace[$];
  int  passed = 0;
  int  total  = 0;
  bit  halt_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit is_illegal(input logic [3:0] op);
`ifdef ACC_SEQ_HALT_EN
    return (op > 4'd4) && (op != 4'd15);
`else
    return op > 4'd4;
`endif
  endfunction

  function automatic bit uses_mem_wait(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
  endfunction

  // accept-to-done cycle count
  function automatic int exp_len(input logic [3:0] op, input int w);
    case (op)
      4'd1:    return 2;
      4'd2:    return 3 + w;
      4'd3:    return 2 + w;
      4'd4:    return 4 + w;
      default: return 1;
    endcase
  endfunction

  // strobes expected in cycle i after accept
  function automatic logic [9:0] exp_vec(input logic [3:0] op, input int w, input int i);
    logic [9:0] v;
    v = '0;
    if (i == exp_len(op, w) - 1) begin
      v[B_DONE] = 1'b1;
      v[B_ILL]  = is_illegal(op);
      return v;
    end
    case (op)
      4'd1: begin v[B_IMMOE] = 1'b1; v[B_LDI] = 1'b1; end
      4'd2: begin
        v[B_MRD] = 1'b1;
        if (i == w + 1) v[B_LDA] = 1'b1;
      end
      4'd3: begin v[B_OE] = 1'b1; v[B_MWR] = 1'b1; end
      4'd4: begin
        if (i <= w + 1) v[B_MRD] = 1'b1;
        if (i == w + 1) v[B_LATCH] = 1'b1;
        if (i == w + 2) begin v[B_ALUOE] = 1'b1; v[B_LDA] = 1'b1; end
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [9:0] out_vec();
    return {load_a, load_immediate_a, output_enable, imm_oe, mem_read,
            mem_write, alu_latch, alu_oe, done, illegal};
  endfunction

  // monitor: per-cycle invariants, trace capture, scoreboard compare on done
  always @(negedge clk) begin
    if (!rst_n) begin
      trace.delete();
    end else begin
      check("bus_single_driver",
            32'(($countones({output_enable, imm_oe, mem_read, alu_oe}) <= 1)), 32'd1);
      check("halted_level", 32'(halted), 32'(halt_exp));
      if (instr_ready) begin
        check("idle_quiet", 32'(out_vec()), 32'd0);
      end else if (!halted) begin
        trace.push_back(out_vec());
        if (trace.size() > 64) begin
          check("trace_bounded", 32'(trace.size()), 32'd64);
          trace.delete();
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          item_t e;
          int    n;
          e = exp_q.pop_front();
          n = exp_len(e.op, e.w);
          check($sformatf("latency_op%0d", e.op), 32'(trace.size()), 32'(n));
          for (int i = 0; i < trace.size() && i < n; i++)
            check($sformatf("strobes_op%0d_cyc%0d", e.op, i), 32'(trace[i]),
                  32'(exp_vec(e.op, e.w, i)));
          check($sformatf("imm_out_op%0d", e.op), 32'(imm_out), 32'(e.operand));
          check($sformatf("mem_addr_op%0d", e.op), 32'(mem_addr), 32'(e.operand));
        end
        trace.delete();
      end
    end
  end

  task automatic present(input item_t it);
    instr_valid   = 1'b1;
    instr_opcode  = it.op;
    instr_operand = it.operand;
  endtask

  // wait (bounded) for IDLE, then let the next edge accept
  task automatic accept_edge(output bit ok);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = instr_ready;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic run_item(input int idx);
    item_t it;
    bit    ok;
    int    len;
    it = items[idx];
    repeat (it.gap) begin
      instr_valid = 1'b0;
      mem_ready   = 1'($urandom);
      @(posedge clk); #1;
    end
    present(it);
    accept_edge(ok);
    if (ok) exp_q.push_back(it);
    #1;
    len = exp_len(it.op, it.w);
    for (int k = 0; k < len; k++) begin
      if (uses_mem_wait(it.op) && k < it.w)       mem_ready = 1'b0;
      else if (uses_mem_wait(it.op) && k == it.w) mem_ready = 1'b1;
      else                                        mem_ready = 1'($urandom);
      if (it.hold && idx + 1 < items.size()) begin
        present(items[idx + 1]);
      end else begin
        instr_valid   = 1'($urandom);
        instr_opcode  = 4'($urandom);
        instr_operand = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    if (!(it.hold && idx + 1 < items.size())) instr_valid = 1'b0;
    check($sformatf("ready_after_done_op%0d", it.op), 32'(instr_ready), 32'd1);
  endtask

  function automatic item_t mk(input logic [3:0] op, input logic [7:0] opd,
                               input int w, input bit hold, input int gap);
    item_t it;
    it.op = op; it.operand = opd; it.w = w; it.hold = hold; it.gap = gap;
    return it;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    bit    ok;
    bit    prev_hold;
    rst_n         = 1'b0;
    instr_valid   = 1'b0;
    instr_opcode  = '0;
    instr_operand = '0;
    mem_ready     = 1'b1;
    #12;
    check("rst_strobes", 32'(out_vec()), 32'd0);
    check("rst_imm_out", 32'(imm_out), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases, then a randomized stream
    items.push_back(mk(4'd1, 8'hA5, 0, 1'b0, 0));
    items.push_back(mk(4'd2, 8'h3C, 2, 1'b0, 1));
    items.push_back(mk(4'd4, 8'h10, 0, 1'b1, 1));
    items.push_back(mk(4'd3, 8'h20, 0, 1'b0, 0));
    items.push_back(mk(4'd7, 8'h55, 0, 1'b0, 1));
    items.push_back(mk(4'd3, 8'hC3, 3, 1'b0, 0));
`ifndef ACC_SEQ_HALT_EN
    items.push_back(mk(4'd15, 8'h0F, 0, 1'b0, 1));
`endif
    prev_hold = 1'b0;
    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom % 8);
      if (r < 5) it.op = 4'(r);
`ifdef ACC_SEQ_HALT_EN
      else it.op = 4'($urandom_range(5, 14));
`else
      else it.op = 4'($urandom_range(5, 15));
`endif
      it.operand = 8'($urandom);
      it.w       = uses_mem_wait(it.op) ? int'($urandom_range(0, 3)) : 0;
      it.hold    = ($urandom % 3) == 0;
      it.gap     = prev_hold ? 0 : int'($urandom_range(0, 2));
      prev_hold  = it.hold;
      items.push_back(it);
    end
    for (int i = 0; i < items.size(); i++) run_item(i);
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of ADD's ALU state
    present(mk(4'd4, 8'h99, 0, 1'b0, 0));
    mem_ready = 1'b1;
    accept_edge(ok);
    if (ok) exp_q.push_back(mk(4'd4, 8'h99, 0, 1'b0, 0));
    #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("alu_latch_before_reset", 32'(alu_latch), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_strobes", 32'(out_vec()), 32'd0);
    check("midrst_ready", 32'(instr_ready), 32'd1);
    check("midrst_imm_out", 32'(imm_out), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    items.delete();
    items.push_back(mk(4'd1, 8'h5A, 0, 1'b0, 0));
    items.push_back(mk(4'd4, 8'h81, 1, 1'b0, 0));
    for (int i = 0; i < items.size(); i++) run_item(i);
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained_end", 32'(exp_q.size()), 32'd0);

`ifdef ACC_SEQ_HALT_EN
    present(mk(4'd15, 8'h00, 0, 1'b0, 0));
    accept_edge(ok);
    #1;
    halt_exp = 1'b1;
    for (int c = 0; c < 20; c++) begin
      present(mk(4'($urandom_range(0, 4)), 8'($urandom), 0, 1'b0, 0));
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_not_ready", 32'(instr_ready), 32'd0);
      check("halt_no_strobes", 32'(out_vec()), 32'd0);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    halt_exp = 1'b0;
    check("halt_cleared_by_reset", 32'(halted), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
